// File: rtl/hms_clock_ctrl_if.sv
// Bus between the time-keeping controller and whatever drives its buttons
// and tick strobe. The master side supplies the strobe and raw buttons; the
// slave side (the controller) returns the registered time, mode and DP flags.
interface hms_clock_ctrl_if;
  logic       tick;
  logic       btnMode;
  logic       btnInc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic [5:0] sixDp;

  modport master (
    output tick, btnMode, btnInc,
    input  sec, min, hour, mode, sixDp
  );

  modport slave (
    input  tick, btnMode, btnInc,
    output sec, min, hour, mode, sixDp
  );
endinterface

// File: rtl/hms_clock_ctrl.sv
// Hours:minutes:seconds keeper with a button-driven set mode.
// A 1 Hz strobe advances the time in CLOCK mode; the mode button walks the
// FSM through SET_SEC, SET_MIN and SET_HOUR, where the increment button
// bumps only the selected field. Decimal-point flags mark the field being
// edited for the downstream display chain.
module hms_clock_ctrl #(
  parameter int HOUR_MAX = 23
) (
  input logic              clk,
  input logic              rst,
  hms_clock_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  localparam logic [5:0] SixtyMax = 6'd59;
  localparam logic [4:0] HourMax  = 5'(HOUR_MAX);

  logic [2:0] modeSync_q;
  logic [2:0] incSync_q;
  logic       modePulse_q;
  logic       incPulse_q;

  state_t     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] dp_q, dp_d;

  logic       secWrap;
  logic       minWrap;
  logic       hourWrap;
  logic [5:0] secInc;
  logic [5:0] minInc;
  logic [4:0] hourInc;

  // Two-flop synchronizer plus a delayed copy; the registered rise pulse lands one cycle later so a rise at cycle N is consumed at the edge ending N+3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modeSync_q  <= '0;
      incSync_q   <= '0;
      modePulse_q <= 1'b0;
      incPulse_q  <= 1'b0;
    end else begin
      modeSync_q  <= {modeSync_q[1:0], bus.btnMode};
      incSync_q   <= {incSync_q[1:0], bus.btnInc};
      modePulse_q <= modeSync_q[1] & ~modeSync_q[2];
      incPulse_q  <= incSync_q[1] & ~incSync_q[2];
    end
  end

  // Wrapped increments of each field, compared at the field's own width.
  always_comb begin
    secWrap  = (sec_q == SixtyMax);
    minWrap  = (min_q == SixtyMax);
    hourWrap = (hour_q == HourMax);
    secInc   = secWrap  ? 6'd0 : sec_q + 6'd1;
    minInc   = minWrap  ? 6'd0 : min_q + 6'd1;
    hourInc  = hourWrap ? 5'd0 : hour_q + 5'd1;
  end

  // Next state, next time and next DP flags; a tick only counts if the pre-transition state is CLOCK, and a mode pulse always beats an inc pulse.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    dp_d    = 6'b000000;

    if (modePulse_q) begin
      unique case (state_q)
        CLOCK:    state_d = SET_SEC;
        SET_SEC:  state_d = SET_MIN;
        SET_MIN:  state_d = SET_HOUR;
        SET_HOUR: state_d = CLOCK;
        default:  state_d = CLOCK;
      endcase
    end

    if (state_q == CLOCK) begin
      if (bus.tick) begin
        sec_d = secInc;
        if (secWrap) begin
          min_d = minInc;
          if (minWrap) begin
            hour_d = hourInc;
          end
        end
      end
    end else if (incPulse_q && !modePulse_q) begin
      unique case (state_q)
        SET_SEC:  sec_d  = secInc;
        SET_MIN:  min_d  = minInc;
        SET_HOUR: hour_d = hourInc;
        default:  sec_d  = sec_q;
      endcase
    end

    unique case (state_d)
      CLOCK:    dp_d = 6'b000000;
      SET_SEC:  dp_d = 6'b000011;
      SET_MIN:  dp_d = 6'b001100;
      SET_HOUR: dp_d = 6'b110000;
      default:  dp_d = 6'b000000;
    endcase
  end

  // State, time fields and DP flags all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLOCK;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.sec   = sec_q;
  assign bus.min   = min_q;
  assign bus.hour  = hour_q;
  assign bus.mode  = state_q;
  assign bus.sixDp = dp_q;

endmodule
